// File: rtl/div_pkg.sv
// div_pkg: shared FSM state and status-vector layout for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ST_W   = 4;
  localparam int ST_DZ  = 0;
  localparam int ST_QZ  = 1;
  localparam int ST_OVF = 2;
  localparam int ST_RNZ = 3;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {rem, q}, no latency, no flow control.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor, so the shifted value minus divisor always fits WIDTH+1 signed bits
  assign shifted = {rem, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt   = {q[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/seq_div.sv
// seq_div: restoring divider, one quotient bit per cycle; SEQ_DIV_SIGNED_EN selects two's-complement operands.
// Latency WIDTH+1 cycles from accepted start to done (2 for div-by-zero / MIN/-1); start ignored unless idle.
import div_pkg::*;

module seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [ST_W-1:0]  status
);
  localparam int CW = $clog2(WIDTH);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] rem_r, q_r, dvs_r, dvd_r;
  logic [WIDTH-1:0] rem_nxt, q_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic            spec_in, spec_r;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic [ST_W-1:0]  st_fin;

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_in, ovf_r, neg_q_r, neg_r_r;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign ovf_in  = (dividend == MIN_VAL) && (&divisor);
  assign spec_in = (divisor == '0) || ovf_in;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign spec_in = (divisor == '0);
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .q       (q_r),
    .divisor (dvs_r),
    .rem_nxt (rem_nxt),
    .q_nxt   (q_nxt)
  );

  // Result as it will be registered on entry to DONE; special cases bypass the iteration.
  always_comb begin
    q_fin  = q_nxt;
    r_fin  = rem_nxt;
    st_fin = '0;
    if (spec_r) begin
      q_fin         = '1;
      r_fin         = dvd_r;
      st_fin[ST_DZ] = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
      if (ovf_r) begin
        q_fin          = MIN_VAL;
        r_fin          = '0;
        st_fin         = '0;
        st_fin[ST_OVF] = 1'b1;
      end
`endif
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      if (neg_q_r) q_fin = -q_nxt;
      if (neg_r_r) r_fin = -rem_nxt;
`endif
      st_fin[ST_QZ]  = (q_fin == '0);
      st_fin[ST_RNZ] = (r_fin != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      dvs_r     <= '0;
      dvd_r     <= '0;
      spec_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      status    <= '0;
`ifdef SEQ_DIV_SIGNED_EN
      ovf_r     <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd_r  <= dividend;
          dvs_r  <= dvs_mag;
          rem_r  <= '0;
          q_r    <= dvd_mag;
          spec_r <= spec_in;
          cnt    <= spec_in ? '0 : CW'(WIDTH - 1);
          state  <= CALC;
`ifdef SEQ_DIV_SIGNED_EN
          ovf_r   <= ovf_in;
          neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_r <= dividend[WIDTH-1];
`endif
        end
        CALC: begin
          rem_r <= rem_nxt;
          q_r   <= q_nxt;
          if (cnt == '0) begin
            state     <= DONE;
            quotient  <= q_fin;
            remainder <= r_fin;
            status    <= st_fin;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed and random divisions against an arithmetic reference model, WIDTH=8.
module tb_seq_div;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic [3:0]   status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .status    (status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Quotient/remainder straight from integer division rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic [3:0] st, output int lat);
`ifdef SEQ_DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = '1; r = a; st = 4'b0001; lat = 2;
    end else if (sa == -(2 ** (W - 1)) && sb == -1) begin
      q = a; r = '0; st = 4'b0100; lat = 2;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb);
      st = {r != 0, 1'b0, q == 0, 1'b0}; lat = W + 1;
    end
`else
    if (b == 0) begin
      q = '1; r = a; st = 4'b0001; lat = 2;
    end else begin
      q = a / b; r = a % b;
      st = {r != 0, 1'b0, q == 0, 1'b0}; lat = W + 1;
    end
`endif
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input string tag);
    logic [W-1:0] eq, er;
    logic [3:0]   es;
    int           elat, lat;
    bit           seen, busy_ok;
    model(a, b, eq, er, es, elat);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_before_done"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_status"}, 32'(status), 32'(es));
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk({tag, "_q_held"}, 32'(quotient), 32'(eq));
    start = 1'b0;
  endtask

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(8'd200, 8'd7, 1'b0, "d200_7");
    run(8'd5, 8'd9, 1'b0, "d5_9");
    run(8'd13, 8'd0, 1'b0, "d13_0");
    run(8'd77, 8'd3, 1'b1, "hold_77_3");
    run(8'd255, 8'd1, 1'b0, "b2b_255_1");

    // Abort in the 4th CALC cycle.
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_status", 32'(status), 32'd0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run(8'd100, 8'd10, 1'b0, "d100_10");

    run(8'hF9, 8'd2, 1'b0, "m7_2");
    run(8'h80, 8'hFF, 1'b0, "min_m1");
    run(8'h80, 8'd1, 1'b0, "min_1");
    run(8'd0, 8'd5, 1'b0, "zero_5");

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 9) == 0) begin a = 8'h80; b = 8'hFF; end
      run(a, b, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
